stack_arbiter: RTL and testbench
================================

# stack_arbiter

Two-port arbiter and sequencer for the shared 22-bit LIFO `stack`. Requester 0 is the tile-placement unit and requester 1 is the forced-move checker. The block grants stack access round-robin and drives the stack's push/pop/reset strobes. It tracks occupancy itself, so overflow and underflow are rejected before they reach the stack, and it returns popped entries with a valid pulse.

## Interface
- `depth`, 21: MSB index of the entry; entries are `depth+1` bits wide.
- `stack_depth`, 6: stack address width; usable capacity is `(1<<stack_depth)-1` = 63 entries.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `r0_req`, `r1_req`  in  1  request; held high until the matching `gnt`.
- `r0_pop`, `r1_pop`  in  1  operation: 1 = pop, 0 = push; held stable with `req`.
- `r0_din`, `r1_din`  in  depth+1  push data; held stable with `req`.
- `r0_gnt`, `r1_gnt`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `gnt`: the operation was rejected (push when full, or pop when empty).
- `rd_data`  out  depth+1  popped entry; holds its value until the next successful pop.
- `rd_valid`  out  1  one-cycle pulse with `gnt` on a successful pop.
- `flush`  in  1  single-cycle pulse that empties the stack.
- `busy`  out  1  high in every state except IDLE.
- `count`  out  stack_depth+1  current occupancy, 0..63.
- `stk_push`, `stk_pop`, `stk_reset`  out  1  registered strobes to the stack.
- `stk_din`  out  depth+1  registered push data to the stack.
- `stk_dout`  in  depth+1  stack top-of-stack (combinational in the stack).
- `stk_empty`  in  1  stack empty flag, used for the consistency check only.

## Operation
- FSM states: FLUSH, IDLE, ISSUE, DONE.
- Reset values:
  - state = FLUSH; `stk_reset` = 1 and `busy` = 1.
  - All other outputs are 0, including `count`, `rd_data` and the round-robin pointer. With the pointer at 0, requester 0 has priority first.
- FLUSH:
  - `stk_reset` is high for exactly one cycle; `count` is set to 0.
  - Next state is IDLE.
- IDLE:
  - `flush` pulses are latched into `flush_pend` in any state.
  - If `flush_pend` is set, go to FLUSH and clear `flush_pend`. Flush has priority over requests.
  - Otherwise, if any `req` is high, pick a winner, register its op/data/id and go to ISSUE.
- Arbitration:
  - A single requester always wins.
  - If both request, the requester not granted last wins.
  - The pointer updates only on a grant, including rejected grants.
- ISSUE:
  - Push with `count` < 63: assert `stk_push` and drive `stk_din`.
  - Pop with `count` > 0: assert `stk_pop` and capture `stk_dout` into `rd_data` at the end of the cycle, before the stack's pointer moves.
  - Push at 63 or pop at 0: no strobe; flag the operation as an error.
  - Next state is DONE.
- DONE:
  - The winner's `gnt` is high for one cycle.
  - `err` reflects the error flag.
  - `rd_valid` is high for a successful pop.
  - `count` has already moved by +1 or -1, or is unchanged on error.
  - Next state is IDLE.
- `count` arithmetic is unsigned `stack_depth+1` bits and never wraps. The stack's `of`/`uf` flags therefore can never set.
- Consistency: in IDLE, `stk_empty` must equal (`count`==0). This is a verification assertion only; no logic depends on it.
- Asserting `reset` in any state aborts the operation in flight: no `gnt` is issued and the FSM returns to FLUSH.

## Timing
- Strobe registers are loaded in the IDLE→ISSUE transition, so `stk_push`/`stk_pop` are high exactly during ISSUE.
- The stack updates on the edge that ends ISSUE.
- Request sampled at edge N (IDLE) → strobe in cycle N+1 → `gnt`/`rd_valid`/`err` in cycle N+2 → IDLE in cycle N+3.
- Throughput is one operation per 3 cycles.
- A requester drops `req` in its `gnt` cycle. Because IDLE follows DONE, no duplicate grant is possible.
- A flush costs 1 cycle (FLUSH) plus return to IDLE. A flush raised during ISSUE/DONE is serviced right after DONE.

## Test plan
- Reset, then idle: `stk_reset` is high for one cycle, then `busy`=0 and `count`=0. A pop by r0 gives `r0_gnt`=1, `err`=1, `rd_valid`=0, and `stk_pop` never asserts.
- r0 pushes 0x000AB then 0x1FFFF, then r1 pops twice: `rd_data` = 0x1FFFF then 0x000AB, `count` goes 1,2,1,0, and each `gnt` arrives 2 cycles after `req` is sampled.
- r0 and r1 request continuously with pushes: grants alternate r0,r1,r0,… After 63 pushes `count`=63, and the 64th push gets `err`=1 with no `stk_push`.
- With `count`=5, pulse `flush` during ISSUE of a push: the push completes (`count`=6), then FLUSH asserts `stk_reset`, leaving `count`=0 and `stk_empty`=1.
- Assert `reset` during ISSUE of a pop: no `gnt`/`rd_valid` is issued, the FSM enters FLUSH, `count`=0, and `rd_data`=0.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter and sequencer in front of the shared
// 22-bit LIFO. Occupancy is tracked here so that push-when-full and
// pop-when-empty are rejected before any strobe reaches the stack.
// One operation takes IDLE -> ISSUE -> DONE (3 cycles); flush runs through
// a one-cycle FLUSH state that pulses stk_reset.
module stack_arbiter #(
    parameter int depth       = 21,
    parameter int stack_depth = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r0_req,
    input  logic                 r0_pop,
    input  logic [depth:0]       r0_din,
    input  logic                 r1_req,
    input  logic                 r1_pop,
    input  logic [depth:0]       r1_din,
    output logic                 r0_gnt,
    output logic                 r1_gnt,
    output logic                 err,
    output logic [depth:0]       rd_data,
    output logic                 rd_valid,
    input  logic                 flush,
    output logic                 busy,
    output logic [stack_depth:0] count,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic                 stk_reset,
    output logic [depth:0]       stk_din,
    input  logic [depth:0]       stk_dout,
    input  logic                 stk_empty
);

    // Usable capacity is one less than the address space of the stack.
    localparam logic [stack_depth:0] FULL = {1'b0, {stack_depth{1'b1}}};
    localparam logic [stack_depth:0] ZERO = '0;
    localparam logic [stack_depth:0] ONE  = {{stack_depth{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic           flush_pend;
    logic           ptr;        // requester that wins a tie next
    logic           op_id;
    logic           op_pop;
    logic           op_err;

    logic           win_id;
    logic           win_pop;
    logic [depth:0] win_din;
    logic           win_ok;

    // Occupancy steps saturate so the counter can never wrap.
    function automatic logic [stack_depth:0] count_inc(input logic [stack_depth:0] c);
        return (c == FULL) ? c : c + ONE;
    endfunction

    function automatic logic [stack_depth:0] count_dec(input logic [stack_depth:0] c);
        return (c == ZERO) ? c : c - ONE;
    endfunction

    // Round-robin winner selection and legality of the winner's operation.
    always_comb begin
        win_id = 1'b0;
        if (r0_req && r1_req) begin
            win_id = ptr;
        end else if (r1_req) begin
            win_id = 1'b1;
        end
        win_pop = win_id ? r1_pop : r0_pop;
        win_din = win_id ? r1_din : r0_din;
        win_ok  = win_pop ? (count != ZERO) : (count != FULL);
    end

    // Sequencer FSM with registered grant, error, read and stack strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
            ptr        <= 1'b0;
            op_id      <= 1'b0;
            op_pop     <= 1'b0;
            op_err     <= 1'b0;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            err        <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b1;
            count      <= '0;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_reset  <= 1'b1;
            stk_din    <= '0;
        end else begin
            // Flush requests are remembered whatever the FSM is doing.
            if (flush) begin
                flush_pend <= 1'b1;
            end
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_reset <= 1'b0;

            case (state)
                FLUSH: begin
                    count <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                IDLE: begin
                    if (flush_pend || flush) begin
                        flush_pend <= 1'b0;
                        stk_reset  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FLUSH;
                    end else if (r0_req || r1_req) begin
                        op_id  <= win_id;
                        op_pop <= win_pop;
                        op_err <= ~win_ok;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                        if (win_ok && win_pop) begin
                            stk_pop <= 1'b1;
                        end
                        if (win_ok && !win_pop) begin
                            stk_push <= 1'b1;
                            stk_din  <= win_din;
                        end
                    end
                end
                ISSUE: begin
                    // Top-of-stack is captured before the stack's pointer moves.
                    if (!op_err) begin
                        if (op_pop) begin
                            rd_data  <= stk_dout;
                            rd_valid <= 1'b1;
                            count    <= count_dec(count);
                        end else begin
                            count <= count_inc(count);
                        end
                    end
                    err    <= op_err;
                    r0_gnt <= ~op_id;
                    r1_gnt <= op_id;
                    state  <= DONE;
                end
                DONE: begin
                    ptr   <= ~op_id;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b1;
                    stk_reset <= 1'b1;
                    state     <= FLUSH;
                end
            endcase
        end
    end

    // Local occupancy must agree with the stack's own empty flag when idle.
    a_empty_consistent: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> (stk_empty == (count == ZERO)));

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural LIFO on the stack side, a reference
// model that predicts each grant, and a scoreboard checked on every gnt.
`timescale 1ns/1ps
module tb_stack_arbiter;

    localparam int DEPTH = 21;
    localparam int SD    = 6;
    localparam int W     = DEPTH + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_pop, r1_req, r1_pop;
    logic [W-1:0]  r0_din, r1_din;
    logic          r0_gnt, r1_gnt, err, rd_valid, flush, busy;
    logic [W-1:0]  rd_data;
    logic [SD:0]   count;
    logic          stk_push, stk_pop, stk_reset, stk_empty;
    logic [W-1:0]  stk_din, stk_dout;

    stack_arbiter #(.depth(DEPTH), .stack_depth(SD)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_pop(r0_pop), .r0_din(r0_din),
        .r1_req(r1_req), .r1_pop(r1_pop), .r1_din(r1_din),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush),
        .busy(busy), .count(count),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_reset(stk_reset),
        .stk_din(stk_din), .stk_dout(stk_dout), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: 64 slots, combinational top-of-stack.
    logic [W-1:0] smem [0:63];
    int sp = 0;
    always @(posedge clk) begin
        if (stk_reset) sp <= 0;
        else if (stk_push && sp < 63) begin smem[sp] <= stk_din; sp <= sp + 1; end
        else if (stk_pop && sp > 0) sp <= sp - 1;
    end
    assign stk_dout  = (sp > 0) ? smem[sp-1] : '0;
    assign stk_empty = (sp == 0);

    // Strobe activity, counted in cycles.
    int push_seen = 0, pop_seen = 0, rst_seen = 0;
    always @(negedge clk) begin
        if (stk_push)  push_seen++;
        if (stk_pop)   pop_seen++;
        if (stk_reset) rst_seen++;
    end

    typedef struct {
        int          id;
        logic        err;
        logic        vld;
        logic [W-1:0] data;
        logic [SD:0] cnt;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0, errors = 0;
    int            model_cnt = 0, model_ptr = 0;
    logic [W-1:0]  model_stk[$];
    logic [W-1:0]  model_rd = '0;

    task automatic model_op(input int id, input logic pop, input logic [W-1:0] din, output exp_t e);
        e.id = id; e.err = 1'b0; e.vld = 1'b0;
        if (pop) begin
            if (model_cnt > 0) begin model_rd = model_stk.pop_back(); model_cnt--; e.vld = 1'b1; end
            else e.err = 1'b1;
        end else begin
            if (model_cnt < 63) begin model_stk.push_back(din); model_cnt++; end
            else e.err = 1'b1;
        end
        e.data = model_rd;
        e.cnt  = (SD+1)'(model_cnt);
        model_ptr = 1 - id;
    endtask

    task automatic model_clear();
        model_stk.delete();
        model_cnt = 0;
    endtask

    // Scoreboard: every grant is compared against the next prediction.
    always @(negedge clk) begin
        if (reset !== 1'b1 && (r0_gnt === 1'b1 || r1_gnt === 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt: got r0_gnt=%b r1_gnt=%b, required no grant", r0_gnt, r1_gnt);
            end else begin
                mon_e = sb.pop_front();
                if ({r1_gnt, r0_gnt} !== (mon_e.id == 1 ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL gnt_id: got r1_gnt,r0_gnt=%b%b, required r%0d", r1_gnt, r0_gnt, mon_e.id);
                end
                checks++;
                if (err !== mon_e.err) begin
                    errors++; $display("FAIL err: got %b, required %b", err, mon_e.err);
                end
                checks++;
                if (rd_valid !== mon_e.vld) begin
                    errors++; $display("FAIL rd_valid: got %b, required %b", rd_valid, mon_e.vld);
                end
                checks++;
                if (rd_data !== mon_e.data) begin
                    errors++; $display("FAIL rd_data: got %h, required %h", rd_data, mon_e.data);
                end
                checks++;
                if (count !== mon_e.cnt) begin
                    errors++; $display("FAIL count_at_gnt: got %0d, required %0d", count, mon_e.cnt);
                end
            end
        end else if (reset !== 1'b1 && rd_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL rd_valid_no_gnt: got %b, required 0", rd_valid);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%b, required 0", busy);
        end
    endtask

    task automatic do_op(input int id, input logic pop, input logic [W-1:0] din);
        exp_t e;
        int   n;
        wait_idle();
        model_op(id, pop, din, e);
        sb.push_back(e);
        if (id == 0) begin r0_req = 1'b1; r0_pop = pop; r0_din = din; end
        else         begin r1_req = 1'b1; r1_pop = pop; r1_din = din; end
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (((id == 0) ? r0_gnt : r1_gnt) !== 1'b1 && n < 20);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL latency_r%0d: got %0d cycles, required 2", id, n);
        end
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({stk_reset, busy} !== 2'b11) begin
            errors++; $display("FAIL reset_strobes: got stk_reset,busy=%b%b, required 11", stk_reset, busy);
        end
        checks++;
        if ({count, rd_data} !== '0) begin
            errors++; $display("FAIL reset_data: got count=%0d rd_data=%h, required 0", count, rd_data);
        end
        checks++;
        if ({r0_gnt, r1_gnt, err, rd_valid, stk_push, stk_pop} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b, required 000000",
                               {r0_gnt, r1_gnt, err, rd_valid, stk_push, stk_pop});
        end
        @(posedge clk); #1 reset = 1'b0;
        hi = 0;
        repeat (3) begin @(negedge clk); if (stk_reset) hi++; end
        checks++;
        if (hi != 1) begin
            errors++; $display("FAIL flush_pulse_len: got %0d cycles, required 1", hi);
        end
        checks++;
        if ({busy, count, stk_empty} !== {1'b0, 7'd0, 1'b1}) begin
            errors++; $display("FAIL after_reset: got busy=%b count=%0d empty=%b, required 0 0 1",
                               busy, count, stk_empty);
        end
    endtask

    task automatic test_pop_empty();
        int p0 = pop_seen;
        do_op(0, 1'b1, '0);
        wait_idle();
        checks++;
        if (pop_seen != p0) begin
            errors++; $display("FAIL pop_empty_strobe: got %0d stk_pop cycles, required 0", pop_seen - p0);
        end
    endtask

    task automatic test_push_pop();
        int p0 = push_seen, q0 = pop_seen;
        do_op(0, 1'b0, 22'h000AB);
        do_op(0, 1'b0, 22'h1FFFF);
        do_op(1, 1'b1, '0);
        do_op(1, 1'b1, '0);
        wait_idle();
        checks++;
        if (push_seen - p0 != 2 || pop_seen - q0 != 2) begin
            errors++; $display("FAIL push_pop_strobes: got push=%0d pop=%0d, required 2 2",
                               push_seen - p0, pop_seen - q0);
        end
    endtask

    task automatic test_alternate();
        exp_t         e;
        int           nxt, first, grants, cyc, p0;
        logic [W-1:0] base;
        wait_idle();
        p0    = push_seen;
        base  = 22'h20000;
        first = model_ptr;
        nxt   = first;
        for (int k = 0; k < 64; k++) begin
            model_op(nxt, 1'b0, base + W'(k), e);
            sb.push_back(e);
            nxt = 1 - nxt;
        end
        if (first == 0) begin r0_din = base; r1_din = base + W'(1); end
        else            begin r1_din = base; r0_din = base + W'(1); end
        r0_pop = 1'b0; r1_pop = 1'b0; r0_req = 1'b1; r1_req = 1'b1;
        grants = 0; cyc = 0;
        while (grants < 64 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (r0_gnt === 1'b1) begin grants++; r0_din = base + W'(grants + 1); end
            if (r1_gnt === 1'b1) begin grants++; r1_din = base + W'(grants + 1); end
            if (grants >= 64) begin r0_req = 1'b0; r1_req = 1'b0; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if (grants != 64) begin
            errors++; $display("FAIL alternate_timeout: got %0d grants, required 64", grants);
        end
        wait_idle();
        checks++;
        if (count !== 7'd63 || push_seen - p0 != 63) begin
            errors++; $display("FAIL full_stack: got count=%0d pushes=%0d, required 63 63",
                               count, push_seen - p0);
        end
    endtask

    task automatic test_flush_issue();
        exp_t e;
        int   r0;
        wait_idle();
        r0 = rst_seen;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        wait_idle();
        model_clear();
        checks++;
        if (rst_seen - r0 != 1 || count !== 7'd0 || stk_empty !== 1'b1) begin
            errors++; $display("FAIL idle_flush: got resets=%0d count=%0d empty=%b, required 1 0 1",
                               rst_seen - r0, count, stk_empty);
        end
        for (int k = 1; k <= 5; k++) do_op(k % 2, 1'b0, W'(k));
        wait_idle();
        r0 = rst_seen;
        model_op(0, 1'b0, 22'h6, e);
        sb.push_back(e);
        r0_req = 1'b1; r0_pop = 1'b0; r0_din = 22'h6;
        @(negedge clk);
        checks++;
        if (stk_push !== 1'b1) begin
            errors++; $display("FAIL issue_push: got stk_push=%b, required 1", stk_push);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; r0_req = 1'b0;
        checks++;
        if (r0_gnt !== 1'b1) begin
            errors++; $display("FAIL flush_push_gnt: got r0_gnt=%b, required 1", r0_gnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stk_reset !== 1'b1) begin
            errors++; $display("FAIL pending_flush: got stk_reset=%b, required 1", stk_reset);
        end
        @(negedge clk);
        model_clear();
        checks++;
        if (rst_seen - r0 != 1 || count !== 7'd0 || stk_empty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_flush: got resets=%0d count=%0d empty=%b busy=%b, required 1 0 1 0",
                               rst_seen - r0, count, stk_empty, busy);
        end
    endtask

    task automatic test_reset_abort();
        int g = 0;
        do_op(0, 1'b0, 22'h000A1);
        do_op(0, 1'b0, 22'h000A2);
        wait_idle();
        r1_req = 1'b1; r1_pop = 1'b1;
        @(negedge clk);
        checks++;
        if (stk_pop !== 1'b1) begin
            errors++; $display("FAIL issue_pop: got stk_pop=%b, required 1", stk_pop);
        end
        reset = 1'b1;
        #1;
        r1_req = 1'b0;
        checks++;
        if ({busy, stk_reset, stk_pop, count, rd_data} !== {1'b1, 1'b1, 1'b0, 7'd0, 22'd0}) begin
            errors++; $display("FAIL abort_state: got busy=%b rst=%b pop=%b count=%0d rd_data=%h, required 1 1 0 0 0",
                               busy, stk_reset, stk_pop, count, rd_data);
        end
        repeat (2) begin @(negedge clk); if (r0_gnt || r1_gnt || rd_valid) g++; end
        @(posedge clk); #1 reset = 1'b0;
        model_clear();
        model_ptr = 0;
        model_rd  = '0;
        repeat (3) begin @(negedge clk); if (r0_gnt || r1_gnt || rd_valid) g++; end
        checks++;
        if (g != 0 || count !== 7'd0 || rd_data !== '0 || stk_empty !== 1'b1) begin
            errors++; $display("FAIL abort_result: got gnts=%0d count=%0d rd_data=%h empty=%b, required 0 0 0 1",
                               g, count, rd_data, stk_empty);
        end
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        int           first, n, cyc;
        logic [W-1:0] d0, d1;
        d0 = 22'h3C3C3; d1 = 22'h0F0F0;
        wait_idle();
        first = model_ptr;
        model_op(first, 1'b0, (first == 0) ? d0 : d1, e);     sb.push_back(e);
        model_op(1 - first, 1'b0, (first == 0) ? d1 : d0, e); sb.push_back(e);
        r0_din = d0; r1_din = d1; r0_pop = 1'b0; r1_pop = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 30) begin
            @(negedge clk); cyc++;
            if (r0_gnt === 1'b1) begin r0_req = 1'b0; n++; end
            if (r1_gnt === 1'b1) begin r1_req = 1'b0; n++; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL b2b_timeout: got %0d grants, required 2", n);
        end
        do_op(0, 1'b1, '0);
        do_op(1, 1'b1, '0);
        wait_idle();
        checks++;
        if (count !== 7'd0 || rd_data !== d0) begin
            errors++; $display("FAIL b2b_final: got count=%0d rd_data=%h, required 0 %h", count, rd_data, d0);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        r0_req = 1'b0; r0_pop = 1'b0; r0_din = '0;
        r1_req = 1'b0; r1_pop = 1'b0; r1_din = '0;
        test_reset();
        test_pop_empty();
        test_push_pop();
        test_alternate();
        test_flush_issue();
        test_reset_abort();
        test_back_to_back();
        wait_idle();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
